run_caller_seq: RTL and testbench

Initiator for the run req/busy/return call protocol used by generated compute blocks. It issues a programmed sequence of calls `f(a_k)` with `a_k = base + k·stride` to one callee, waits for each call to complete, and accumulates the returned values. It sits between a control register block and a single generated callee, and it owns the callee's `i_run_req` and `i_run_input_a_0` inputs.

---
 rtl/run_call_pkg.sv | 34 +++
 rtl/run_timeout_ctr.sv | 36 +++
 rtl/run_caller_seq.sv | 147 ++++++++++++++
 tb/tb_run_caller_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/run_call_pkg.sv
// run_call_pkg: shared types for the run req/busy/return call initiator.
//   call_state_e     : sequencer state encoding
//   *_TIMEOUT_DEF    : default timeout budgets in ce-cycles
//   run_call_if_t    : one-callee call bundle (req, arg, busy, ret)
//   tmo_width()      : counter width that holds the larger timeout
package run_call_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    FINISH,
    ERROR
  } call_state_e;

  localparam int ACK_TIMEOUT_DEF  = 4;
  localparam int DONE_TIMEOUT_DEF = 1023;
  localparam int RUN_W            = 32;

  typedef struct packed {
    logic             req;
    logic [RUN_W-1:0] arg;
    logic             busy;
    logic [RUN_W-1:0] ret;
  } run_call_if_t;

  function automatic int tmo_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/run_timeout_ctr.sv
// run_timeout_ctr: loadable down-counter used as a watchdog.
//   clock, reset_n : clock, async active-low reset
//   ce             : clock enable, counter frozen when low
//   clear          : force count to zero (priority over load)
//   load, load_val : load the timeout budget
//   dec            : count one elapsed cycle
//   expired        : the current counted cycle is the last one allowed
module run_timeout_ctr #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ce,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (ce) begin
      if (clear)                    cnt <= '0;
      else if (load)                cnt <= load_val;
      else if (dec && cnt != '0)    cnt <= cnt - 1'b1;
    end
  end

  // Loaded with N, a watchdog firing on cnt==1 allows exactly N counted cycles.
  assign expired = (cnt == W'(1));

endmodule

// File: rtl/run_caller_seq.sv
// run_caller_seq: issues f(base + k*stride), k = 0..count-1, to one callee over
// the run req/busy/return protocol and accumulates the returns.
//   clock, reset_n   : clock, async active-low reset
//   ce               : clock enable, everything freezes when low
//   i_start          : start a sequence (ignored while o_busy)
//   i_count/i_base/i_stride : call count, first argument, argument step
//   o_busy, o_done   : sequence in progress / one-cycle end pulse
//   o_error          : sticky timeout flag, cleared by next accepted start
//   o_sum, o_calls   : running sum of returns / completed calls
//   o_call_req, o_call_input_a : callee request pulse and argument
//   i_call_busy, i_call_return : callee busy and return value
module run_caller_seq
  import run_call_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 8,
  parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_stride,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [WIDTH-1:0] o_sum,
  output logic [CNT_W-1:0] o_calls,
  output logic             o_call_req,
  output logic [WIDTH-1:0] o_call_input_a,
  input  logic             i_call_busy,
  input  logic [WIDTH-1:0] i_call_return
);

  localparam int TW = tmo_width(ACK_TIMEOUT, DONE_TIMEOUT);

  call_state_e      state, state_nx;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] stride_q;
  logic             accept, capture;
  logic             tmo_load, tmo_dec, tmo_exp;
  logic [TW-1:0]    tmo_val;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else if (ce)  state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    o_call_req = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    tmo_load   = 1'b0;
    tmo_dec    = 1'b0;
    tmo_val    = '0;
    case (state)
      IDLE: begin
        if (i_start) begin
          accept   = 1'b1;
          state_nx = (i_count == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        // Hold off while the callee is still busy from an earlier call;
        // leaving ISSUE immediately makes req a single-cycle pulse.
        if (!i_call_busy) begin
          o_call_req = 1'b1;
          tmo_load   = 1'b1;
          tmo_val    = TW'(ACK_TIMEOUT);
          state_nx   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_call_busy) begin
          tmo_load = 1'b1;
          tmo_val  = TW'(DONE_TIMEOUT);
          state_nx = WAIT_DONE;
        end else begin
          tmo_dec = 1'b1;
          if (tmo_exp) state_nx = ERROR;
        end
      end
      WAIT_DONE: begin
        if (i_call_busy) begin
          tmo_dec = 1'b1;
          if (tmo_exp) state_nx = ERROR;
        end else begin
          capture  = 1'b1;
          state_nx = ((o_calls + 1'b1) == count_q) ? FINISH : ISSUE;
        end
      end
      FINISH:  state_nx = IDLE;
      ERROR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);
  assign o_done = (state == FINISH) || (state == ERROR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= '0;
      stride_q       <= '0;
      o_sum          <= '0;
      o_calls        <= '0;
      o_call_input_a <= '0;
      o_error        <= 1'b0;
    end else if (ce) begin
      if (accept) begin
        count_q        <= i_count;
        stride_q       <= i_stride;
        o_sum          <= '0;
        o_calls        <= '0;
        o_error        <= 1'b0;
        o_call_input_a <= i_base;
      end else begin
        // The argument only moves after the return is captured, so it is
        // stable from ISSUE through the callee's sampling edge.
        if (capture) begin
          o_sum          <= o_sum + i_call_return;
          o_calls        <= o_calls + 1'b1;
          o_call_input_a <= o_call_input_a + stride_q;
        end
        if (state_nx == ERROR) o_error <= 1'b1;
      end
    end
  end

  // One watchdog serves both phases: reloaded with the ack budget on issue
  // and with the done budget once the callee acknowledges.
  run_timeout_ctr #(.W(TW)) u_tmo (
    .clock    (clock),
    .reset_n  (reset_n),
    .ce       (ce),
    .clear    (state == IDLE),
    .load     (tmo_load),
    .load_val (tmo_val),
    .dec      (tmo_dec),
    .expired  (tmo_exp)
  );

endmodule

// File: tb/tb_run_caller_seq.sv
module tb_run_caller_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce;
  logic        i_start = 1'b0;
  logic [7:0]  i_count = '0;
  logic [31:0] i_base = '0, i_stride = '0;
  logic        o_busy, o_done, o_error, o_call_req, i_call_busy;
  logic [31:0] o_sum, o_call_input_a, i_call_return;
  logic [7:0]  o_calls;

  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  run_caller_seq dut (
    .clock(clock), .reset_n(reset_n), .ce(ce), .i_start(i_start),
    .i_count(i_count), .i_base(i_base), .i_stride(i_stride),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_sum(o_sum),
    .o_calls(o_calls), .o_call_req(o_call_req), .o_call_input_a(o_call_input_a),
    .i_call_busy(i_call_busy), .i_call_return(i_call_return)
  );

  // Free-running cycle count; ce gaps and forced-busy windows key off it.
  int gcyc = 0;
  int gap_lo = 1 << 30;
  int fb_lo  = 1 << 30;
  always @(posedge clock) gcyc <= gcyc + 1;
  assign ce = !(gcyc >= gap_lo && gcyc < gap_lo + 3);
  logic fb;
  assign fb = (gcyc >= fb_lo && gcyc < fb_lo + 5);

  // Callee model: accepts req, busy for cal_b cycles, returns arg*cal_mul.
  int          cal_b = 10;
  logic [31:0] cal_mul = 1;
  bit          never_ack = 0;
  logic        cb;
  int          ccnt;
  logic [31:0] cret;
  logic [31:0] args[$];
  int          reqt[$];
  int          req_hi = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cb <= 1'b0; ccnt <= 0; cret <= '0;
    end else if (ce) begin
      if (o_call_req && !cb && !never_ack) begin
        cb <= 1'b1; ccnt <= cal_b; cret <= o_call_input_a * cal_mul;
        args.push_back(o_call_input_a);
        reqt.push_back(gcyc);
      end else if (cb) begin
        ccnt <= ccnt - 1;
        if (ccnt == 1) cb <= 1'b0;
      end
    end
  end
  always @(posedge clock) if (reset_n && ce && o_call_req) req_hi <= req_hi + 1;

  assign i_call_busy   = cb | fb;
  assign i_call_return = cret;

  typedef struct {
    string       nm;
    int          cnt;
    logic [31:0] base, stride;
    int          b, mul;
    bit          never_ack, busy5, gap, poke;
    logic [31:0] exp_sum;
    int          exp_calls, exp_lat;
    bit          exp_err;
    int          exp_reqs;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Latency = posedges from the accepting edge (counted as 1) until o_done is seen.
  task automatic run_seq(input vec_t v);
    int lat, a0, r0, q0;
    logic [31:0] a;
    cal_b = v.b; cal_mul = v.mul; never_ack = v.never_ack;
    @(negedge clock);
    a0 = args.size(); q0 = reqt.size(); r0 = req_hi;
    i_count = v.cnt[7:0]; i_base = v.base; i_stride = v.stride; i_start = 1'b1;
    if (v.busy5) fb_lo = gcyc + 1;
    if (v.gap)   gap_lo = gcyc + 6;
    @(posedge clock); #1;
    i_start = 1'b0;
    lat = 1;
    while (!o_done && lat < 3000) begin
      @(posedge clock); #1;
      lat++;
      if (v.poke && lat == 5) begin i_start = 1'b1; i_count = 8'd0; end
      if (v.poke && lat == 6) i_start = 1'b0;
    end
    chk({v.nm, "_lat"},   lat, v.exp_lat);
    chk({v.nm, "_busy"},  o_busy, 1);
    chk({v.nm, "_sum"},   o_sum, v.exp_sum);
    chk({v.nm, "_calls"}, o_calls, v.exp_calls);
    chk({v.nm, "_err"},   o_error, v.exp_err);
    @(posedge clock); #1;
    chk({v.nm, "_idle"},  {o_done, o_busy}, 0);
    fb_lo = 1 << 30; gap_lo = 1 << 30;
    chk({v.nm, "_reqs"},  req_hi - r0, v.exp_reqs);
    chk({v.nm, "_nargs"}, args.size() - a0, v.never_ack ? 0 : v.exp_calls);
    a = v.base;
    for (int k = 0; k < v.exp_calls && a0 + k < args.size(); k++) begin
      chk({v.nm, "_arg"}, args[a0 + k], a);
      a = a + v.stride;
    end
    if (!v.gap && !v.busy5 && !v.never_ack)
      for (int k = q0 + 1; k < reqt.size(); k++)
        chk({v.nm, "_spacing"}, reqt[k] - reqt[k-1], v.b + 2);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t r;
    logic [31:0] s, a;

    vecs[0] = '{"ident", 1, 32'd7, 32'd0, 10, 1, 0, 0, 0, 0, 32'd7, 1, 13, 0, 1};
    vecs[1] = '{"seq", 4, -32'sd2, 32'd3, 10, 1, 0, 0, 0, 1, 32'd10, 4, 49, 0, 4};
    vecs[2] = '{"zero", 0, 32'd5, 32'd1, 10, 1, 0, 0, 0, 0, 32'd0, 0, 1, 0, 0};
    vecs[3] = '{"acktmo", 3, 32'd5, 32'd1, 10, 1, 1, 0, 0, 0, 32'd0, 0, 6, 1, 1};
    vecs[4] = '{"errclr", 1, 32'd7, 32'd0, 10, 1, 0, 0, 0, 0, 32'd7, 1, 13, 0, 1};
    vecs[5] = '{"busy5", 1, 32'd9, 32'd0, 3, 1, 0, 1, 0, 0, 32'd9, 1, 11, 0, 1};
    vecs[6] = '{"cegap", 1, 32'd7, 32'd0, 10, 1, 0, 0, 1, 0, 32'd7, 1, 16, 0, 1};
    vecs[7] = '{"wrap", 2, 32'h7FFF_FFFF, 32'd1, 2, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 2, 9, 0, 2};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_flags", {o_busy, o_done, o_error, o_call_req}, 0);
    chk("rst_sum",   o_sum, 0);
    chk("rst_calls", o_calls, 0);
    chk("rst_arg",   o_call_input_a, 0);
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 8; i++) run_seq(vecs[i]);

    // Random sequences against a closed-form reference.
    for (int i = 0; i < 20; i++) begin
      r = vecs[0];
      r.nm = "rand";
      r.cnt = $urandom_range(1, 6);
      r.b = $urandom_range(1, 8);
      r.mul = $urandom_range(1, 7);
      r.base = $urandom; r.stride = $urandom;
      s = 0; a = r.base;
      for (int k = 0; k < r.cnt; k++) begin
        s = s + a * 32'(r.mul);
        a = a + r.stride;
      end
      r.exp_sum = s; r.exp_calls = r.cnt; r.exp_reqs = r.cnt;
      r.exp_lat = r.cnt * (r.b + 2) + 1;
      run_seq(r);
    end

    // Asynchronous reset while the second request is on the wire.
    cal_b = 10; cal_mul = 1; never_ack = 0;
    @(negedge clock);
    i_count = 8'd3; i_base = 32'd1; i_stride = 32'd1; i_start = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
    begin
      int k;
      k = 0;
      while (!(o_call_req && o_calls == 8'd1) && k < 100) begin
        @(posedge clock); #1;
        k++;
      end
      chk("rst_reach", k < 100, 1);
    end
    chk("rst_pre_sum", o_sum, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_flags", {o_busy, o_done, o_error, o_call_req}, 0);
    chk("arst_sum",   o_sum, 0);
    chk("arst_calls", o_calls, 0);
    chk("arst_arg",   o_call_input_a, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    run_seq(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
